// File: rtl/pio_in_debounced_irq_if.sv
// Avalon-MM slave bus bundle for the debounced input PIO.
// The Nios II data master drives the master side; the PIO takes the slave side.
interface pio_in_debounced_irq_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/pio_in_debounced_irq.sv
// Input PIO: per-bit synchroniser and debounce filter, edge capture register
// (write-1-to-clear), maskable level interrupt, and registered read data.
module pio_in_debounced_irq #(
    parameter int unsigned WIDTH           = 18,
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 1,
    parameter int unsigned EDGE_TYPE       = 0
) (
    input  logic                    clk,
    input  logic                    reset_n,
    pio_in_debounced_irq_if.slave   bus,
    input  logic [WIDTH-1:0]        in_port,
    output logic                    irq
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        REG_DATA = 2'd0,
        REG_RAW  = 2'd1,
        REG_MASK = 2'd2,
        REG_EDGE = 2'd3
    } reg_sel_e;

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] d_prev;
    logic [CW-1:0]    cnt [WIDTH];
    logic [WIDTH-1:0] edge_hit;
    logic [WIDTH-1:0] irqmask;
    logic [WIDTH-1:0] edgecapture;
    logic [WIDTH-1:0] clr_bits;
    logic [31:0]      rd_mux;
    logic             wr_en;
    reg_sel_e         sel;
    logic             unused_wd;

    assign sel       = reg_sel_e'(bus.address);
    assign wr_en     = bus.chipselect & bus.write;
    assign unused_wd = ^{1'b0, bus.writedata};

    // Synchroniser chain; the last stage is the synchronised value.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= in_port;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    // Debounce: d only takes s after DEBOUNCE_CYCLES consecutive mismatching cycles.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            d <= '0;
            for (int unsigned i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < WIDTH; i++) begin
                if (s[i] == d[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    d[i]   <= s[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            d_prev <= '0;
        end else begin
            d_prev <= d;
        end
    end

    always_comb begin
        edge_hit = '0;
        if (EDGE_TYPE == 0) begin
            edge_hit = d & ~d_prev;
        end else if (EDGE_TYPE == 1) begin
            edge_hit = ~d & d_prev;
        end else begin
            edge_hit = d ^ d_prev;
        end
    end

    always_comb begin
        clr_bits = '0;
        if (wr_en && sel == REG_EDGE) begin
            clr_bits = bus.writedata[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irqmask <= '0;
        end else if (wr_en && sel == REG_MASK) begin
            irqmask <= bus.writedata[WIDTH-1:0];
        end
    end

    // A new edge on the same cycle as its clear keeps the bit set.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            edgecapture <= '0;
        end else begin
            edgecapture <= (edgecapture & ~clr_bits) | edge_hit;
        end
    end

    assign irq = |(edgecapture & irqmask);

    always_comb begin
        rd_mux = '0;
        unique case (sel)
            REG_DATA: rd_mux[WIDTH-1:0] = d;
            REG_RAW:  rd_mux[WIDTH-1:0] = s;
            REG_MASK: rd_mux[WIDTH-1:0] = irqmask;
            REG_EDGE: rd_mux[WIDTH-1:0] = edgecapture;
            default:  rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.readdata <= '0;
        end else begin
            bus.readdata <= rd_mux;
        end
    end

endmodule
